seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Multiplexed seven-segment display driver. It consumes the packed BCD/hex digit values produced by the stopwatch counter chain and time-multiplexes them onto a common-anode display: one digit per scan slot, with registered segment and anode outputs. It sits between the counter digits and the board display pins.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (2..8).
REFRESH_DIV, 25000, clk cycles per digit slot (4 kHz slot / 1 kHz frame at 100 MHz clock).
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.
ACTIVE_LOW, 1, 1 = segments and anodes driven active-low; 0 = active-high.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
enable  in  1  1 = scanning runs; 0 = display dark, scan state frozen
digits_in  in  4*NUM_DIGITS  packed digit values; digit 0 = bits [3:0] = rightmost digit
dp_in  in  NUM_DIGITS  decimal point request per digit
seg_out  out  7  segments {g,f,e,d,c,b,a}
dp_out  out  1  decimal point segment
an_out  out  NUM_DIGITS  digit anode selects, one-hot active when lit
frame_tick  out  1  one-cycle pulse when the digit snapshot is taken

Behaviour:
- Reset (rst=0, asynchronous): prescaler=0, scan index=0, snapshot regs=0, all anodes/segments/dp inactive (all 1s when ACTIVE_LOW=1), frame_tick=0. Release is synchronous to the next clk edge.
- Prescaler counts 0..REFRESH_DIV-1 while enable=1, wraps to 0; its terminal count advances the scan index 0,1,..,NUM_DIGITS-1, then wraps to 0.
- Snapshot: digits_in and dp_in are captured into internal regs on the cycle the index wraps to 0 (and once on the first enabled cycle after reset); frame_tick pulses that same cycle. The digits of one frame never tear mid-scan.
- Slot timing: for prescaler values 0..BLANK_CYCLES-1, an_out is all inactive; otherwise exactly one anode (the current index) is active. seg_out/dp_out are registered: they reflect the current index one cycle after the index changes, i.e. always valid before the anode turns on.
- Decode: values 0-9 give standard digits; A-F give hex glyphs (A,b,C,d,E,F). All 16 codes are defined.
- enable=0: prescaler and index hold; an_out all inactive the next cycle; segments are don't-care but held. Re-enable resumes the same slot at its held prescaler value. No frame_tick is issued while disabled.
- enable toggled on the terminal-count cycle: the disable takes priority and the index does not advance.
- Reset mid-slot: outputs go dark immediately; the scan restarts at digit 0 with a fresh snapshot.

Optional Feature:
Macro SEG7_LZB_EN (leading-zero blanking). When defined: during the snapshot, digit k (k >= 1) is marked blank if it and all higher digits are 0 and the corresponding dp_in bits are 0; a blank digit's slot keeps its anode inactive. Digit 0 is never blanked. When undefined, all digits are always lit and no blank-mask logic is synthesised.

Decomposition:
- Shared package seg7_pkg: 16-entry glyph constant table (active-high a..g), an ACTIVE_LOW polarity helper function, and a scan-index width function (clog2 of NUM_DIGITS).
- One combinational sub-module seg7_decode (4-bit value in, 7-bit active-high segments out), instantiated once on the muxed digit. Prescaler, index and snapshot logic stay in the top level.

Test Plan:
- Reset: hold rst=0 with REFRESH_DIV=4 -> an_out=4'b1111, seg_out=7'b1111111, frame_tick=0; after release with enable=1, frame_tick pulses on the first cycle.
- Scan order: digits_in=16'h1234, REFRESH_DIV=4, BLANK_CYCLES=1 -> active anodes cycle 1110, 1101, 1011, 0111 with segments for 4, 3, 2, 1; each anode is on for 3 of every 4 cycles, and frame_tick occurs every 16 cycles.
- Snapshot isolation: change digits_in from 16'h1234 to 16'h5678 while the index is 2 -> digits 2 and 3 still show 2 and 1; 5678 appears only after the next frame_tick.
- Hex decode: digits_in=16'hABCD -> digit 0 slot seg_out=7'b0100001 (d, active-low), digit 3 slot seg_out=7'b0001000 (A).
- Enable freeze: drop enable during the digit-1 slot for 10 cycles -> an_out=1111 throughout; after re-enable the digit-1 slot completes its remaining cycles, with no frame_tick during the pause.
- With SEG7_LZB_EN, digits_in=16'h0050, dp_in=0 -> digits 3 and 2 are never lit, digits 1 and 0 show 5 and 0; with digits_in=16'h0000, only digit 0 is lit, showing 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph table,
// output polarity helper and scan-index width helper.
package seg7_pkg;

  // Largest display supported by the driver.
  localparam int MAX_DIGITS = 8;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}, indexed by digit value.
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

  // XOR mask that converts active-high drive levels to pin levels.
  // It also equals the "inactive" pin level for every segment/anode.
  function automatic logic [7:0] polarity_mask(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

  // Width of the scan index register; never narrower than one bit.
  function automatic int scan_idx_w(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder (active-high segments).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // All sixteen codes map to a defined glyph, so no default case is needed.
  always_comb begin
    seg = SEG7_GLYPH[value];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver for a common-anode display.
// A prescaler divides the clock into digit slots; each slot starts with a
// short all-dark blanking window, then lights the current digit. Digit values
// are snapshotted once per frame so a frame never mixes old and new digits.
// Segment, dp and anode outputs are registered.
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 25000,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int IW = scan_idx_w(NUM_DIGITS);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [7:0]            POL_MASK = polarity_mask(ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF  = POL_MASK[6:0];
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = POL_MASK[NUM_DIGITS-1:0];
  localparam logic                  DP_OFF   = POL_MASK[0];

  // Scan state
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          primed;

  // Per-frame digit snapshot
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;

  // Slot control and muxed digit
  logic                  presc_tc;
  logic                  frame_wrap;
  logic                  take_snap;
  logic [3:0]            cur_value;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] an_hot;
  logic                  slot_lit;

  // Terminal count, frame wrap, and when to capture a fresh snapshot.
  // The very first enabled cycle after reset only primes the snapshot.
  always_comb begin
    presc_tc   = (presc == PRESC_LAST);
    frame_wrap = presc_tc && (idx == IDX_LAST);
    take_snap  = enable && (!primed || frame_wrap);
  end

  // Prescaler and scan index; everything holds while enable is low, so a
  // disable on the terminal-count cycle also suppresses the index advance.
  // On the priming cycle the prescaler stays at 0 so the first frame has
  // the same shape as every later one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc  <= '0;
      idx    <= '0;
      primed <= 1'b0;
    end else if (enable) begin
      if (!primed) begin
        primed <= 1'b1;
      end else if (presc_tc) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Snapshot registers and the frame pulse that marks each capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= take_snap;
      if (take_snap) begin
        snap_digits <= digits_in;
        snap_dp     <= dp_in;
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] blank_next;
  logic [NUM_DIGITS-1:0] snap_blank;
  logic                  zero_above;

  // A digit blanks when it and every higher digit are zero with no dp
  // requested; digit 0 always stays lit.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above && (digits_in[4*k +: 4] == 4'h0) && !dp_in[k];
      blank_next[k] = zero_above;
    end
  end

  // Blank mask is captured alongside the digits so it matches the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_blank <= '0;
    end else if (take_snap) begin
      snap_blank <= blank_next;
    end
  end

  // Blank flag of the digit currently being scanned.
  always_comb begin
    cur_blank = snap_blank[idx];
  end
`else
  // Without leading-zero blanking every digit is lit in its slot.
  always_comb begin
    cur_blank = 1'b0;
  end
`endif

  // Select the digit for the current slot from the frame snapshot.
  always_comb begin
    cur_value = snap_digits[{idx, 2'b00} +: 4];
    cur_dp    = snap_dp[idx];
  end

  seg7_decode u_decode (
    .value (cur_value),
    .seg   (glyph)
  );

  // One-hot anode for the current index, lit only after the blanking window.
  always_comb begin
    an_hot      = '0;
    an_hot[idx] = 1'b1;
    slot_lit    = primed && (presc >= BLANK_END) && !cur_blank;
  end

  // Registered pin drivers. Segments follow the index one cycle after it
  // changes, which lands inside the dark window before the anode turns on.
  // While disabled the anodes go dark and the segment levels are held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_out  <= AN_OFF;
      seg_out <= SEG_OFF;
      dp_out  <= DP_OFF;
    end else if (!enable) begin
      an_out <= AN_OFF;
    end else begin
      an_out  <= slot_lit ? (an_hot ^ AN_OFF) : AN_OFF;
      seg_out <= glyph ^ SEG_OFF;
      dp_out  <= cur_dp ^ DP_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots, 1 blank
// cycle, active-low). Stimulus pushes expected display events; a monitor
// condenses the pin activity into lit runs and frame pulses and checks them.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  // Active-low pin patterns {g,f,e,d,c,b,a} for 0..F.
  logic [6:0] seg_al [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    bit         is_frame;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;    // lit-run length, or frame gap (0 = first after reset)
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push_slot(input int d, input int v, input logic dp, input int len);
    rec_t r;
    r.is_frame = 1'b0;
    r.an       = ~(4'b0001 << d);
    r.seg      = seg_al[v];
    r.dp       = dp;
    r.len      = len;
    exp_q.push_back(r);
  endtask

  task automatic push_frame(input int gap);
    rec_t r;
    r.is_frame = 1'b1;
    r.an       = 4'hF;
    r.seg      = 7'h7F;
    r.dp       = 1'b1;
    r.len      = gap;
    exp_q.push_back(r);
  endtask

  // Full undisturbed frame: digits 0..2, frame pulse, then digit 3.
  task automatic push_full_frame(input int v3, input int v2, input int v1, input int v0,
                                 input logic [3:0] dpm, input int gap);
    push_slot(0, v0, ~dpm[0], 3);
    push_slot(1, v1, ~dpm[1], 3);
    push_slot(2, v2, ~dpm[2], 3);
    push_frame(gap);
    push_slot(3, v3, ~dpm[3], 3);
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_event(input bit is_frame, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp, input int len);
    rec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got frame=%0d an=%b seg=%b dp=%b len=%0d, none expected",
               is_frame, an, seg, dp, len);
      return;
    end
    e = exp_q.pop_front();
    if (e.is_frame != is_frame) begin
      errors++;
      $display("FAIL event_kind: got frame=%0d an=%b seg=%b len=%0d, expected frame=%0d an=%b seg=%b",
               is_frame, an, seg, len, e.is_frame, e.an, e.seg);
    end else if (is_frame) begin
      if (e.len != 0 && e.len != len) begin
        errors++;
        $display("FAIL frame_gap: got %0d cycles, expected %0d", len, e.len);
      end
    end else if (an !== e.an || seg !== e.seg || dp !== e.dp || len != e.len) begin
      errors++;
      $display("FAIL slot: got an=%b seg=%b dp=%b len=%0d, expected an=%b seg=%b dp=%b len=%0d",
               an, seg, dp, len, e.an, e.seg, e.dp, e.len);
    end
  endtask

  // Monitor: frame pulses and lit runs of constant {an,seg,dp}.
  logic       run_open = 1'b0;
  logic [3:0] run_an;
  logic [6:0] run_seg;
  logic       run_dp;
  int         run_len = 0;
  int         gap_cnt = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      gap_cnt++;
      if (frame_tick === 1'b1) begin
        check_event(1'b1, 4'hF, 7'h7F, 1'b1, gap_cnt);
        gap_cnt = 0;
      end
    end else begin
      gap_cnt = 0;
    end
    if (run_open && (an_out === 4'hF || {an_out, seg_out, dp_out} !== {run_an, run_seg, run_dp})) begin
      check_event(1'b0, run_an, run_seg, run_dp, run_len);
      run_open = 1'b0;
    end
    if (an_out !== 4'hF && rst === 1'b1) begin
      if (!run_open) begin
        run_open = 1'b1;
        run_an   = an_out;
        run_seg  = seg_out;
        run_dp   = dp_out;
        run_len  = 1;
      end else begin
        run_len++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    enable    = 1'b1;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_an", 8'(an_out), 8'h0F);
    check_val("reset_seg", 8'(seg_out), 8'h7F);
    check_val("reset_dp", 8'(dp_out), 8'h01);
    check_val("reset_tick", 8'(frame_tick), 8'h00);

    // Expected display sequence for the main run.
    push_frame(0);
    push_full_frame(1, 2, 3, 4, 4'b0000, 16);            // frame 1
    push_full_frame(1, 2, 3, 4, 4'b0000, 16);            // frame 2: 5678 arrives mid-frame
    push_full_frame(5, 6, 7, 8, 4'b0000, 16);            // frame 3
    push_slot(0, 'hD, 1'b1, 3);                          // frame 4: pause inside digit 1
    push_slot(1, 'hC, 1'b1, 1);
    push_slot(1, 'hC, 1'b1, 2);
    push_slot(2, 'hB, 1'b1, 3);
    push_frame(26);
    push_slot(3, 'hA, 1'b1, 3);
    push_full_frame('hA, 'hB, 'hC, 'hD, 4'b0100, 16);    // frame 5 with dp on digit 2
    push_slot(0, 'hD, 1'b1, 1);                          // frame 6 cut short by reset

    rst = 1'b1;                                          // next posedge is edge 0
    repeat (26) @(posedge clk);                          // edges 0..25, index 2 of frame 2
    #1;
    digits_in = 16'h5678;
    repeat (15) @(posedge clk);                          // edges 26..40
    #1;
    digits_in = 16'hABCD;
    repeat (14) @(posedge clk);                          // edges 41..54, first lit cycle of digit 1
    #1;
    enable = 1'b0;
    dp_in  = 4'b0100;
    repeat (10) @(posedge clk);                          // edges 55..64 paused
    #1;
    enable = 1'b1;
    repeat (28) @(posedge clk);                          // edges 65..92
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("midreset_an", 8'(an_out), 8'h0F);
    check_val("midreset_seg", 8'(seg_out), 8'h7F);
    check_val("midreset_dp", 8'(dp_out), 8'h01);
    check_val("midreset_tick", 8'(frame_tick), 8'h00);

    digits_in = 16'h0050;
    dp_in     = 4'b0000;
    push_frame(0);
`ifdef SEG7_LZB_EN
    push_slot(0, 0, 1'b1, 3);
    push_slot(1, 5, 1'b1, 3);
    push_frame(16);
    push_slot(0, 0, 1'b1, 3);
    push_frame(16);
`else
    push_full_frame(0, 0, 5, 0, 4'b0000, 16);
    push_full_frame(0, 0, 0, 0, 4'b0000, 16);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);                           // edges 0..4
    #1;
    digits_in = 16'h0000;
    repeat (29) @(posedge clk);                          // edges 5..33
    #1;
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_val("events_left", 8'(exp_q.size()), 8'h00);
    check_val("run_left_open", 8'(run_open), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
